game_controller: RTL
====================

// Module: game_controller
// PURPOSE
//  Top-level sequencer for the Starflux datapath. Generates the one-cycle strobes that drive it:
//  startGameEn, shipUpdateEn, gridUpdateEn, health_update, current_score_update, plus gameover_signal.
//  Runs a fixed per-frame schedule (ship, then grid, then commit collisions) from a frame-rate tick.
//  Sits beside datapath in the top level; its outputs connect directly to the same-named datapath inputs.
// PARAMETERS
//  FRAME_DIV   833333  clk cycles per game frame (50 MHz / 60 Hz); legal range >= 8
//  CNT_W       20      frame counter width; must satisfy 2**CNT_W >= FRAME_DIV
// PORTS
//  clk                  in   1  system clock, 50 MHz; the only clock
//  reset                in   1  synchronous, active-high reset
//  go                   in   1  start/restart request, level, already synchronised; acted on at rising edge
//  ship_health          in   4  current health from datapath
//  hit_ship             in   1  1-cycle pulse: enemy bullet reached ship
//  hit_enemy            in   1  1-cycle pulse: user bullet reached enemy
//  startGameEn          out  1  1-cycle pulse: datapath clears and initialises all state
//  shipUpdateEn         out  1  1-cycle pulse: move ship / enemy this frame
//  gridUpdateEn         out  1  1-cycle pulse: advance bullet grid this frame
//  health_update        out  1  1-cycle pulse: decrement health
//  current_score_update out  1  1-cycle pulse: increment score
//  gameover_signal      out  1  level: high while in GAMEOVER
//  state_dbg            out  3  current state encoding, for LEDs/debug
// BEHAVIOUR
//  Reset: state=IDLE; all pulses 0; gameover_signal=0; frame counter=0; pending bits=0; go_q=0.
//  go edge: go_rise = go & ~go_q, go_q registered every cycle; a held go triggers only once.
//  States (all transitions on clk edge; outputs are registered, decoded from state):
//   IDLE     : wait; go_rise -> START.
//   START    : startGameEn=1 for exactly 1 cycle; counter:=0; pending:=0 -> WAIT.
//   WAIT     : counter increments; when counter==FRAME_DIV-1 -> counter:=0, -> SHIP.
//   SHIP     : shipUpdateEn=1 (1 cycle) -> GRID.
//   GRID     : gridUpdateEn=1 (1 cycle) -> COMMIT.
//   COMMIT   : health_update=pend_ship; current_score_update=pend_enemy (both may pulse same cycle);
//              pend bits cleared; if ship_health==0 or (ship_health==1 & pend_ship) -> GAMEOVER,
//              else -> WAIT.
//   GAMEOVER : gameover_signal=1; counter frozen; hit pulses ignored; go_rise -> START.
//  Frame counter keeps counting during SHIP/GRID/COMMIT, so frame period is exactly FRAME_DIV cycles;
//   FRAME_DIV>=8 guarantees the tick never lands outside WAIT.
//  Pending bits: pend_ship/pend_enemy set by hit_ship/hit_enemy in WAIT/SHIP/GRID; multiple hits in
//   one frame collapse to one update. Hit arriving in the COMMIT cycle is kept for the next frame
//   (clear-then-set: set wins). Hits in IDLE/GAMEOVER/START are dropped.
//  go_rise in WAIT/SHIP/GRID/COMMIT: ignored (no mid-game restart).
//  reset in any state, mid-frame included: returns to IDLE next cycle, no pulse emitted that cycle.
//  At most one of startGameEn/shipUpdateEn/gridUpdateEn high in any cycle.
//  Latency: go_rise -> startGameEn 2 cycles after go rises; first shipUpdateEn FRAME_DIV+1 cycles
//   after startGameEn.
// STRUCTURE
//  Shared include game_defs.vh: state localparams IDLE=0 START=1 WAIT=2 SHIP=3 GRID=4 COMMIT=5
//   GAMEOVER=6, and FRAME_DIV default, reused by datapath debug and top-level.
//  Sub-module frame_tick_gen (counter, clear, enable, tick out) is natural; FSM, edge detect and
//   pending bits stay in game_controller.
// TESTING (bench uses FRAME_DIV=8)
//  1 reset held 3 cycles, go=0 -> all outputs 0, state_dbg=0 indefinitely.
//  2 go 0->1 and held 50 cycles, ship_health=5 -> exactly one startGameEn; shipUpdateEn then
//    gridUpdateEn on consecutive cycles every 8 cycles; no health/score pulses.
//  3 hit_enemy twice + hit_ship once within one frame -> one current_score_update and one
//    health_update, same cycle, in COMMIT right after gridUpdateEn.
//  4 ship_health=1, hit_ship in frame -> health_update in COMMIT, next cycle gameover_signal=1;
//    further ticks produce no strobes; go_rise -> startGameEn, gameover_signal=0.
//  5 hit_ship coincident with COMMIT cycle -> no pulse that frame, health_update next frame.
//  6 reset asserted during GRID cycle -> next cycle IDLE, no gridUpdateEn/COMMIT pulses afterwards.

Source files
------------

// File: rtl/game_controller_pkg.sv
// Shared definitions for the Starflux game sequencer: state encoding, default frame timing
// and the hit-acceptance window.
package game_controller_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StWait     = 3'd2,
        StShip     = 3'd3,
        StGrid     = 3'd4,
        StCommit   = 3'd5,
        StGameover = 3'd6
    } state_e;

    // 50 MHz system clock divided down to a 60 Hz game frame.
    localparam int unsigned FrameDivDefault = 833333;
    localparam int unsigned CntWDefault     = 20;

    // Hits are only collected while a game frame is in progress.
    function automatic logic hits_accepted(state_e s);
        return (s == StWait) || (s == StShip) || (s == StGrid) || (s == StCommit);
    endfunction

endpackage

// File: rtl/game_controller_frame_tick_gen.sv
// Free-running frame counter: counts while enabled, wraps at FRAME_DIV-1 and flags the wrap
// cycle with a one-cycle tick.
module game_controller_frame_tick_gen #(
    parameter int unsigned FRAME_DIV = 833333,
    parameter int unsigned CNT_W     = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [CNT_W-1:0] LastCount = CNT_W'(FRAME_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = enable && (cnt_q == LastCount);
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_controller.sv
// Starflux sequencer: turns a frame-rate tick into the ship/grid/commit strobe schedule and
// tracks start, collision bookkeeping and game over. All outputs are registered from the state.
module game_controller
    import game_controller_pkg::*;
#(
    parameter int unsigned FRAME_DIV = FrameDivDefault,
    parameter int unsigned CNT_W     = CntWDefault
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [3:0] ship_health,
    input  logic       hit_ship,
    input  logic       hit_enemy,
    output logic       startGameEn,
    output logic       shipUpdateEn,
    output logic       gridUpdateEn,
    output logic       health_update,
    output logic       current_score_update,
    output logic       gameover_signal,
    output logic [2:0] state_dbg
);

    state_e state_q, state_d;
    logic   go_q;
    logic   pend_ship_q, pend_ship_d;
    logic   pend_enemy_q, pend_enemy_d;
    logic   start_q, start_d;
    logic   ship_q, ship_d;
    logic   grid_q, grid_d;
    logic   health_q, health_d;
    logic   score_q, score_d;
    logic   over_q, over_d;

    logic go_rise;
    logic cnt_clear;
    logic cnt_en;
    logic frame_tick;
    logic ship_dies;

    game_controller_frame_tick_gen #(
        .FRAME_DIV (FRAME_DIV),
        .CNT_W     (CNT_W)
    ) u_frame_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .tick   (frame_tick)
    );

    assign go_rise   = go & ~go_q;
    assign ship_dies = (ship_health == 4'd0) || ((ship_health == 4'd1) && pend_ship_q);

    always_comb begin
        state_d      = state_q;
        pend_ship_d  = pend_ship_q;
        pend_enemy_d = pend_enemy_q;
        cnt_clear    = 1'b0;
        cnt_en       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (go_rise) state_d = StStart;
            end
            StStart: begin
                cnt_clear    = 1'b1;
                pend_ship_d  = 1'b0;
                pend_enemy_d = 1'b0;
                state_d      = StWait;
            end
            StWait: begin
                cnt_en = 1'b1;
                if (frame_tick) state_d = StShip;
            end
            StShip: begin
                cnt_en  = 1'b1;
                state_d = StGrid;
            end
            StGrid: begin
                cnt_en  = 1'b1;
                state_d = StCommit;
            end
            StCommit: begin
                // Counter keeps running so the frame period stays exactly FRAME_DIV cycles.
                cnt_en       = 1'b1;
                pend_ship_d  = 1'b0;
                pend_enemy_d = 1'b0;
                state_d      = ship_dies ? StGameover : StWait;
            end
            StGameover: begin
                if (go_rise) state_d = StStart;
            end
            default: state_d = StIdle;
        endcase

        // A hit landing in the commit cycle belongs to the next frame, so set beats clear.
        if (hits_accepted(state_q)) begin
            if (hit_ship)  pend_ship_d  = 1'b1;
            if (hit_enemy) pend_enemy_d = 1'b1;
        end
    end

    always_comb begin
        start_d  = (state_q == StStart);
        ship_d   = (state_q == StShip);
        grid_d   = (state_q == StGrid);
        health_d = (state_q == StCommit) && pend_ship_q;
        score_d  = (state_q == StCommit) && pend_enemy_q;
        over_d   = (state_q == StGameover);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            go_q         <= 1'b0;
            pend_ship_q  <= 1'b0;
            pend_enemy_q <= 1'b0;
            start_q      <= 1'b0;
            ship_q       <= 1'b0;
            grid_q       <= 1'b0;
            health_q     <= 1'b0;
            score_q      <= 1'b0;
            over_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            go_q         <= go;
            pend_ship_q  <= pend_ship_d;
            pend_enemy_q <= pend_enemy_d;
            start_q      <= start_d;
            ship_q       <= ship_d;
            grid_q       <= grid_d;
            health_q     <= health_d;
            score_q      <= score_d;
            over_q       <= over_d;
        end
    end

    assign startGameEn          = start_q;
    assign shipUpdateEn         = ship_q;
    assign gridUpdateEn         = grid_q;
    assign health_update        = health_q;
    assign current_score_update = score_q;
    assign gameover_signal      = over_q;
    assign state_dbg            = state_q;

    strobes_exclusive: assert property (@(posedge clk) $onehot0({start_q, ship_q, grid_q}));

endmodule
